// File: rtl/div_seq_64bit.sv
// Sequential unsigned 64-bit restoring divider: one trial subtraction per clock
// through a shared 64-bit adder/subtractor, with a start/done handshake.

module add_sub_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        mode,
  output logic [63:0] sum,
  output logic        carry_flag,
  output logic        overflow_flag
);
  logic [63:0] b_eff;
  logic [64:0] full;

  always_comb begin
    b_eff         = b ^ {64{mode}};
    full          = {1'b0, a} + {1'b0, b_eff} + {64'd0, mode};
    sum           = full[63:0];
    carry_flag    = full[64];
    overflow_flag = (a[63] == b_eff[63]) && (full[63] != a[63]);
  end
endmodule

module div_seq_64bit #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] r, q, d;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_shift, diff, r_next, q_next;
  logic             carry, ovf_unused, take;

  assign a_shift = {r[WIDTH-2:0], q[WIDTH-1]};

  add_sub_64bit u_add_sub (
    .a            (a_shift),
    .b            (d),
    .mode         (1'b1),
    .sum          (diff),
    .carry_flag   (carry),
    .overflow_flag(ovf_unused)
  );

  // A set R[63] means the shifted value exceeds 64 bits, so it is certainly >= D;
  // because R < D the wrapped 64-bit difference is still the exact remainder.
  always_comb begin
    take   = r[WIDTH-1] | carry;
    r_next = take ? diff : a_shift;
    q_next = {q[WIDTH-2:0], take};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count       <= '0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              r     <= '0;
              q     <= dividend;
              d     <= divisor;
              count <= CNT_W'(WIDTH);
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          r     <= r_next;
          q     <= q_next;
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq_64bit.sv
// Self-checking bench for div_seq_64bit: directed handshake cases plus random
// operands compared against plain '/' and '%' arithmetic.

module tb_div_seq_64bit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [63:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  div_seq_64bit #(.WIDTH(64), .CNT_W(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands with start high for exactly one rising edge.
  task automatic issue(input logic [63:0] dvd, input logic [63:0] dvs);
    start = 1'b1; dividend = dvd; divisor = dvs;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom(); divisor = $urandom();
  endtask

  task automatic wait_done(output int lat, output int bcyc, output bit stable);
    logic [63:0] q0, r0;
    logic        z0;
    q0 = quotient; r0 = remainder; z0 = div_by_zero;
    lat = 1; bcyc = 0; stable = 1'b1;
    while (!done && lat < 200) begin
      if (busy) bcyc++;
      if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input logic [63:0] dvd, input logic [63:0] dvs);
    logic [63:0] eq, er;
    eq = (dvs == 0) ? ONES : dvd / dvs;
    er = (dvs == 0) ? dvd  : dvd % dvs;
    check("quotient",    quotient,    eq);
    check("remainder",   remainder,   er);
    check("div_by_zero", {63'd0, div_by_zero}, {63'd0, dvs == 0});
  endtask

  task automatic do_op(input logic [63:0] dvd, input logic [63:0] dvs);
    int lat, bcyc;
    bit stable;
    issue(dvd, dvs);
    wait_done(lat, bcyc, stable);
    check("latency",     64'(lat),  (dvs == 0) ? 64'd1 : 64'd65);
    check("busy_cycles", 64'(bcyc), (dvs == 0) ? 64'd0 : 64'd64);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    check("stable",      {63'd0, stable}, 64'd1);
    check_result(dvd, dvs);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_pulse", {63'd0, done}, 64'd0);
    check("idle_busy",  {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int lat, bcyc;
    bit stable;
    logic [63:0] dvd, dvs;

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_q",    quotient,  64'd0);
    check("rst_r",    remainder, 64'd0);
    check("rst_dbz",  {63'd0, div_by_zero}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(64'd100, 64'd7);
    check("q_100_7", quotient, 64'd14);
    idle_cycle();
    do_op(ONES, 64'd1);
    do_op(ONES, 64'h8000_0000_0000_0001);
    check("r_hi_path", remainder, 64'h7FFF_FFFF_FFFF_FFFE);
    do_op(64'd5, ONES);
    idle_cycle();
    do_op(64'h1234, 64'd0);
    idle_cycle();
    do_op(64'd9, 64'd3);
    idle_cycle();

    // Start pulsed during CALC must be ignored.
    issue(64'd1000, 64'd10);
    repeat (19) begin @(posedge clk); #1; end
    issue(64'd7, 64'd7);
    wait_done(lat, bcyc, stable);
    check("ignored_lat", 64'(lat), 64'd45);
    check("ignored_q",   quotient,  64'd100);
    check("ignored_r",   remainder, 64'd0);
    // Start held in the DONE cycle is accepted back-to-back.
    do_op(64'd7, 64'd7);
    idle_cycle();

    // Asynchronous reset in the middle of an operation.
    issue(64'd1000, 64'd10);
    repeat (29) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    check("mid_rst_done", {63'd0, done}, 64'd0);
    check("mid_rst_q",    quotient,  64'd0);
    check("mid_rst_r",    remainder, 64'd0);
    check("mid_rst_dbz",  {63'd0, div_by_zero}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      check("no_done_after_rst", {63'd0, done | busy}, 64'd0);
    end
    do_op(64'd50, 64'd6);
    idle_cycle();

    for (int i = 0; i < 1000; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      dvd = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      if (sel == 0) begin
        dvs = '0;
      end else if (sel == 1) begin
        if (dvd == ONES) dvd = dvd - 1;
        dvs = dvd + 1 + (({$urandom(), $urandom()} >> $urandom_range(1, 63)) & ~dvd);
        if (dvs <= dvd) dvs = dvd + 1;
      end else begin
        dvs = {$urandom(), $urandom()} >> $urandom_range(0, 63);
        if (dvs == 0) dvs = 64'd1;
      end
      do_op(dvd, dvs);
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
